// File: rtl/faux_sata_hd_oob.sv
// Device-side SATA OOB / link bring-up model: answers COMRESET/COMWAKE,
// sends dial-tone then ALIGN until the host locks, then idles on SYNC/HOLD.
//
// state          | meaning
// ---------------+-----------------------------------------------------
// S_IDLE         | link down, transmitter quiet
// S_COMINIT_WAIT | COMRESET seen, counting down to COMINIT
// S_SEND_COMINIT | one-cycle COMINIT pulse to host
// S_WAIT_COMWAKE | waiting for host COMWAKE
// S_SEND_COMWAKE | one-cycle COMWAKE pulse to host
// S_DIAL         | dial-tone, waiting for host ALIGN (with timeout)
// S_ALIGN        | sending ALIGN, waiting for 3 host non-ALIGN primitives
// S_READY        | link up, SYNC/HOLD with periodic ALIGN pairs
module faux_sata_hd_oob #(
  parameter int COMINIT_DELAY  = 16,
  parameter int DIAL_TIMEOUT   = 2048,
  parameter int ALIGN_INTERVAL = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        comm_reset_detect,
  input  logic        comm_wake_detect,
  input  logic [31:0] rx_din,
  input  logic [3:0]  rx_isk,
  input  logic        rx_is_elec_idle,
  input  logic        dbg_hold,
  output logic [31:0] tx_dout,
  output logic [3:0]  tx_isk,
  output logic        tx_comm_reset,
  output logic        tx_comm_wake,
  output logic        rx_byte_is_aligned,
  output logic        hd_ready
);

  localparam logic [31:0] PRIM_ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] PRIM_SYNC  = 32'hB5B5957C;
  localparam logic [31:0] PRIM_HOLD  = 32'hD5D5AA7C;
  localparam logic [31:0] PRIM_DIAL  = 32'h4A4A4A4A;
  localparam logic [3:0]  ISK_PRIM   = 4'b0001;

  localparam int CNT_MAX = (COMINIT_DELAY > DIAL_TIMEOUT) ? COMINIT_DELAY : DIAL_TIMEOUT;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam int SLOT_W  = (ALIGN_INTERVAL > 2) ? $clog2(ALIGN_INTERVAL) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMINIT_WAIT,
    S_SEND_COMINIT,
    S_WAIT_COMWAKE,
    S_SEND_COMWAKE,
    S_DIAL,
    S_ALIGN,
    S_READY
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [1:0]          run_cnt, run_nxt;
  logic [SLOT_W-1:0]   slot_cnt, slot_nxt;

  logic        host_align;
  logic        host_non_align;
  logic [31:0] dout_nxt;
  logic [3:0]  isk_nxt;
  logic        creset_nxt;
  logic        cwake_nxt;
  logic        aligned_nxt;
  logic        ready_nxt;

  assign host_align     = !rx_is_elec_idle && (rx_din == PRIM_ALIGN) && (rx_isk == ISK_PRIM);
  assign host_non_align = (rx_isk == ISK_PRIM) && (rx_din != PRIM_ALIGN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      run_cnt  <= '0;
      slot_cnt <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      run_cnt  <= run_nxt;
      slot_cnt <= slot_nxt;
    end
  end

  // COMRESET overrides everything, including a coincident COMWAKE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    run_nxt   = run_cnt;
    slot_nxt  = slot_cnt;
    if (comm_reset_detect) begin
      state_nxt = S_COMINIT_WAIT;
      cnt_nxt   = '0;
      run_nxt   = '0;
      slot_nxt  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_IDLE;
        end
        S_COMINIT_WAIT: begin
          if (cnt == CNT_W'(COMINIT_DELAY - 1)) begin
            state_nxt = S_SEND_COMINIT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_SEND_COMINIT: begin
          state_nxt = S_WAIT_COMWAKE;
        end
        S_WAIT_COMWAKE: begin
          if (comm_wake_detect) state_nxt = S_SEND_COMWAKE;
        end
        S_SEND_COMWAKE: begin
          state_nxt = S_DIAL;
          cnt_nxt   = '0;
        end
        S_DIAL: begin
          if (host_align) begin
            state_nxt = S_ALIGN;
            run_nxt   = '0;
            cnt_nxt   = '0;
          end else if (cnt == CNT_W'(DIAL_TIMEOUT - 1)) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_ALIGN: begin
          if (host_non_align) begin
            if (run_cnt == 2'd2) begin
              state_nxt = S_READY;
              run_nxt   = '0;
              slot_nxt  = '0;
            end else begin
              run_nxt = run_cnt + 2'd1;
            end
          end else begin
            run_nxt = '0;
          end
        end
        S_READY: begin
          // slot_cnt tracks the slot of the dword currently on tx_dout
          if (slot_cnt == SLOT_W'(ALIGN_INTERVAL - 1)) slot_nxt = '0;
          else                                         slot_nxt = slot_cnt + SLOT_W'(1);
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          run_nxt   = '0;
          slot_nxt  = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    dout_nxt    = '0;
    isk_nxt     = '0;
    creset_nxt  = 1'b0;
    cwake_nxt   = 1'b0;
    aligned_nxt = 1'b0;
    ready_nxt   = 1'b0;
    case (state_nxt)
      S_SEND_COMINIT: creset_nxt = 1'b1;
      S_SEND_COMWAKE: cwake_nxt  = 1'b1;
      S_DIAL: begin
        dout_nxt = PRIM_DIAL;
      end
      S_ALIGN: begin
        dout_nxt    = PRIM_ALIGN;
        isk_nxt     = ISK_PRIM;
        aligned_nxt = 1'b1;
      end
      S_READY: begin
        isk_nxt     = ISK_PRIM;
        aligned_nxt = 1'b1;
        ready_nxt   = 1'b1;
        if (slot_nxt >= SLOT_W'(ALIGN_INTERVAL - 2)) dout_nxt = PRIM_ALIGN;
        else if (dbg_hold)                           dout_nxt = PRIM_HOLD;
        else                                         dout_nxt = PRIM_SYNC;
      end
      default: begin
        dout_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_dout            <= '0;
      tx_isk             <= '0;
      tx_comm_reset      <= 1'b0;
      tx_comm_wake       <= 1'b0;
      rx_byte_is_aligned <= 1'b0;
      hd_ready           <= 1'b0;
    end else begin
      tx_dout            <= dout_nxt;
      tx_isk             <= isk_nxt;
      tx_comm_reset      <= creset_nxt;
      tx_comm_wake       <= cwake_nxt;
      rx_byte_is_aligned <= aligned_nxt;
      hd_ready           <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_faux_sata_hd_oob.sv
// Bench for faux_sata_hd_oob: timestamp-based link model checked every cycle,
// plus literal expectations at hand-computed cycles.
module tb_faux_sata_hd_oob;

  localparam int D  = 16;
  localparam int DT = 2048;
  localparam int AI = 256;

  localparam logic [31:0] P_ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] P_SYNC  = 32'hB5B5957C;
  localparam logic [31:0] P_HOLD  = 32'hD5D5AA7C;
  localparam logic [31:0] P_DIAL  = 32'h4A4A4A4A;

  logic        clk = 1'b0;
  logic        rst;
  logic        comm_reset_detect;
  logic        comm_wake_detect;
  logic [31:0] rx_din;
  logic [3:0]  rx_isk;
  logic        rx_is_elec_idle;
  logic        dbg_hold;
  logic [31:0] tx_dout;
  logic [3:0]  tx_isk;
  logic        tx_comm_reset;
  logic        tx_comm_wake;
  logic        rx_byte_is_aligned;
  logic        hd_ready;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic chk_en = 1'b0;

  faux_sata_hd_oob #(.COMINIT_DELAY(D), .DIAL_TIMEOUT(DT), .ALIGN_INTERVAL(AI)) dut (
    .clk                (clk),
    .rst                (rst),
    .comm_reset_detect  (comm_reset_detect),
    .comm_wake_detect   (comm_wake_detect),
    .rx_din             (rx_din),
    .rx_isk             (rx_isk),
    .rx_is_elec_idle    (rx_is_elec_idle),
    .dbg_hold           (dbg_hold),
    .tx_dout            (tx_dout),
    .tx_isk             (tx_isk),
    .tx_comm_reset      (tx_comm_reset),
    .tx_comm_wake       (tx_comm_wake),
    .rx_byte_is_aligned (rx_byte_is_aligned),
    .hd_ready           (hd_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Link model: a phase plus the edge index at which that phase began.
  localparam int PH_IDLE = 0, PH_OOB = 1, PH_DIAL = 2, PH_ALN = 3, PH_RDY = 4;
  int ph, t0, run, me, d, slot;
  logic [31:0] e_dout;
  logic [3:0]  e_isk;
  logic        e_creset, e_cwake, e_aligned, e_ready;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      me = 0; ph = PH_IDLE; t0 = 0; run = 0;
    end else begin
      me = me + 1;
      if (comm_reset_detect) begin
        ph = PH_OOB; t0 = me;
      end else begin
        case (ph)
          PH_OOB: if (comm_wake_detect && me >= t0 + D + 2) begin ph = PH_DIAL; t0 = me; end
          PH_DIAL: begin
            d = me - t0;
            if (d >= 2 && !rx_is_elec_idle && rx_din == P_ALIGN && rx_isk == 4'b0001) begin
              ph = PH_ALN; t0 = me; run = 0;
            end else if (d >= DT + 1) ph = PH_IDLE;
          end
          PH_ALN: begin
            if (rx_isk == 4'b0001 && rx_din != P_ALIGN) begin
              run = run + 1;
              if (run == 3) begin ph = PH_RDY; t0 = me; end
            end else run = 0;
          end
          default: ;
        endcase
      end
    end
    e_dout = 32'h0; e_isk = 4'h0; e_creset = 1'b0; e_cwake = 1'b0;
    e_aligned = 1'b0; e_ready = 1'b0;
    case (ph)
      PH_OOB: e_creset = (me == t0 + D);
      PH_DIAL: begin
        e_cwake = (me == t0);
        if (me > t0) e_dout = P_DIAL;
      end
      PH_ALN: begin e_dout = P_ALIGN; e_isk = 4'b0001; e_aligned = 1'b1; end
      PH_RDY: begin
        slot = (me - t0) % AI;
        e_isk = 4'b0001; e_aligned = 1'b1; e_ready = 1'b1;
        if (slot >= AI - 2) e_dout = P_ALIGN;
        else                e_dout = dbg_hold ? P_HOLD : P_SYNC;
      end
      default: ;
    endcase
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors = vectors + 1;
      if ({tx_dout, tx_isk, tx_comm_reset, tx_comm_wake, rx_byte_is_aligned, hd_ready} !==
          {e_dout, e_isk, e_creset, e_cwake, e_aligned, e_ready}) begin
        miscompares = miscompares + 1;
        $display("FAIL model cyc=%0d got dout=%h isk=%b cr=%b cw=%b al=%b rdy=%b exp dout=%h isk=%b cr=%b cw=%b al=%b rdy=%b",
                 cyc, tx_dout, tx_isk, tx_comm_reset, tx_comm_wake, rx_byte_is_aligned, hd_ready,
                 e_dout, e_isk, e_creset, e_cwake, e_aligned, e_ready);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors = vectors + 1;
    if (got !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_dout"}, tx_dout, 32'h0);
    chk({nm, "_isk"}, {28'h0, tx_isk}, 32'h0);
    chk({nm, "_flags"}, {28'h0, tx_comm_reset, tx_comm_wake, rx_byte_is_aligned, hd_ready}, 32'h0);
  endtask

  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    comm_reset_detect = 1'b0;
    comm_wake_detect  = 1'b0;
    rx_din = 32'h0; rx_isk = 4'h0; rx_is_elec_idle = 1'b1; dbg_hold = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;
    at(2);  chk_all_zero("reset");

    at(10); comm_reset_detect = 1'b1;
    at(11); comm_reset_detect = 1'b0;
    at(26); chk("cominit_early", {31'h0, tx_comm_reset}, 32'h0);
    at(27); chk("cominit_pulse", {31'h0, tx_comm_reset}, 32'h1);
            chk("cominit_dout", tx_dout, 32'h0);
    at(28); chk("cominit_late", {31'h0, tx_comm_reset}, 32'h0);

    at(35); comm_wake_detect = 1'b1;
    at(36); comm_wake_detect = 1'b0;
            chk("comwake_pulse", {31'h0, tx_comm_wake}, 32'h1);
    at(37); chk("comwake_end", {31'h0, tx_comm_wake}, 32'h0);
            chk("dial_first", tx_dout, P_DIAL);
            chk("dial_isk", {28'h0, tx_isk}, 32'h0);
    at(2084); chk("dial_last", tx_dout, P_DIAL);
    at(2085); chk("dial_timeout", tx_dout, 32'h0);

    at(2090); comm_reset_detect = 1'b1;
    at(2091); comm_reset_detect = 1'b0;
    at(2107); chk("cominit2", {31'h0, tx_comm_reset}, 32'h1);
    at(2115); comm_wake_detect = 1'b1;
    at(2116); comm_wake_detect = 1'b0;
    at(2130); rx_din = P_ALIGN; rx_isk = 4'b0001; rx_is_elec_idle = 1'b0;
    at(2131); chk("align_tx", tx_dout, P_ALIGN);
              chk("align_isk", {28'h0, tx_isk}, 32'h1);
              chk("align_aligned", {31'h0, rx_byte_is_aligned}, 32'h1);
              rx_din = P_SYNC;
    at(2133); rx_din = P_ALIGN;
    at(2134); rx_din = P_SYNC;
    at(2136); chk("ready_not_yet", {31'h0, hd_ready}, 32'h0);
    at(2137); chk("ready_rise", {31'h0, hd_ready}, 32'h1);
              chk("ready_first_sync", tx_dout, P_SYNC);
              rx_is_elec_idle = 1'b1;

    at(2390); chk("slot253", tx_dout, P_SYNC);
    at(2391); chk("slot254", tx_dout, P_ALIGN);
    at(2392); chk("slot255", tx_dout, P_ALIGN);
    at(2393); chk("slot0", tx_dout, P_SYNC);

    at(2640); dbg_hold = 1'b1;
    at(2641); chk("hold_first", tx_dout, P_HOLD);
    at(2647); chk("hold_align", tx_dout, P_ALIGN);
    at(2650); chk("hold_mid", tx_dout, P_HOLD);
    at(2660); dbg_hold = 1'b0;
    at(2661); chk("hold_release", tx_dout, P_SYNC);

    at(2700); comm_reset_detect = 1'b1; comm_wake_detect = 1'b1;
    at(2701); comm_reset_detect = 1'b0; comm_wake_detect = 1'b0;
              chk("rdy_drop", {30'h0, hd_ready, rx_byte_is_aligned}, 32'h0);
              chk("reset_beats_wake", {31'h0, tx_comm_wake}, 32'h0);
    at(2705); comm_reset_detect = 1'b1;
    at(2706); comm_reset_detect = 1'b0;
    at(2710); comm_wake_detect = 1'b1;
    at(2711); comm_wake_detect = 1'b0;
    at(2717); chk("restart_old", {31'h0, tx_comm_reset}, 32'h0);
    at(2722); chk("restart_new", {31'h0, tx_comm_reset}, 32'h1);
    at(2730); comm_wake_detect = 1'b1;
    at(2731); comm_wake_detect = 1'b0;
              chk("comwake3", {31'h0, tx_comm_wake}, 32'h1);
    at(2740); #2 rst = 1'b0;
    #1 chk_all_zero("async_rst");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    at(3);  chk_all_zero("post_rst");
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
